// File: rtl/door_pkg.sv
// -----------------------------------------------------------------------------
// door_pkg
// Shared types and constants for the cab door controller.
//   state_t          : FSM state encoding (3 bits; codes 4-7 are illegal and
//                      recover to CLOSED)
//   DEF_*            : default tick constants for the door controller
//   timer_width()    : width of the shared stroke/dwell timer
//   nudge_width()    : width of the obstruction-reversal counter (min 2 bits)
// Optional feature macro used by the controller: DOOR_NUDGE_EN.
// -----------------------------------------------------------------------------
package door_pkg;

   typedef enum logic [2:0] {
      CLOSED  = 3'd0,
      OPENING = 3'd1,
      OPEN    = 3'd2,
      CLOSING = 3'd3
   } state_t;

   localparam int DEF_MOVE_TICKS  = 4;
   localparam int DEF_DWELL_TICKS = 10;
   localparam int DEF_NUDGE_LIMIT = 3;

   // The timer must be able to hold the larger of the two terminal counts.
   function automatic int timer_width(input int move_ticks, input int dwell_ticks);
      int longest;
      longest = (move_ticks > dwell_ticks) ? move_ticks : dwell_ticks;
      return $clog2(longest + 1);
   endfunction

   function automatic int nudge_width(input int nudge_limit);
      int w;
      w = $clog2(nudge_limit + 1);
      return (w < 2) ? 2 : w;
   endfunction

endpackage

// File: rtl/door_timer.sv
// -----------------------------------------------------------------------------
// door_timer
// Loadable saturating up-counter shared by the stroke (open/close) and dwell
// phases of the door controller. It never wraps: once count reaches terminal
// it stays there until cleared or loaded.
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset (count -> 0)
//   clear      in   count -> 0 (highest priority after reset)
//   load       in   count -> load_value
//   load_value in   value taken on load
//   hold       in   freeze count
//   terminal   in   saturation value; done is flagged at or above it
//   count      out  current count
//   done       out  count has reached terminal
// -----------------------------------------------------------------------------
module door_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             hold,
   input  logic [WIDTH-1:0] terminal,
   output logic [WIDTH-1:0] count,
   output logic             done
);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (!hold && (count < terminal)) begin
         count <= count + 1'b1;
      end
   end

   assign done = (count >= terminal);

endmodule

// File: rtl/door_controller.sv
// -----------------------------------------------------------------------------
// door_controller
// Cab door state machine: CLOSED -> OPENING -> OPEN (dwell) -> CLOSING ->
// CLOSED. Closing is inhibited (and a closing stroke reversed) by open_req,
// obstruction, weight_limit_exceeded or sos_mode. door_closed is the travel
// controller's only permission to move the car.
// Optional feature macro: DOOR_NUDGE_EN -- after NUDGE_LIMIT consecutive
// reversals caused by obstruction alone, the next close ignores obstruction
// and the extra `nudge` output is high for that closing stroke.
// Ports:
//   clk                   in   system clock
//   reset_n               in   synchronous active-low reset
//   at_floor              in   car levelled; door may only leave CLOSED when high
//   open_req              in   level open request
//   close_btn             in   cut dwell short
//   obstruction           in   light curtain blocked
//   weight_limit_exceeded in   from emergency block
//   sos_mode              in   from emergency block
//   door                  out  door not fully closed
//   door_closed           out  fully closed and locked
//   motor_open            out  drive motor opening
//   motor_close           out  drive motor closing
//   state                 out  encoded FSM state (debug)
//   nudge                 out  (DOOR_NUDGE_EN only) nudge close in progress
// All outputs decode registers only; there is no input-to-output path.
// -----------------------------------------------------------------------------
module door_controller
   import door_pkg::*;
#(
   parameter int MOVE_TICKS  = DEF_MOVE_TICKS,
   parameter int DWELL_TICKS = DEF_DWELL_TICKS
`ifdef DOOR_NUDGE_EN
   ,
   parameter int NUDGE_LIMIT = DEF_NUDGE_LIMIT
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       at_floor,
   input  logic       open_req,
   input  logic       close_btn,
   input  logic       obstruction,
   input  logic       weight_limit_exceeded,
   input  logic       sos_mode,
   output logic       door,
   output logic       door_closed,
   output logic       motor_open,
   output logic       motor_close,
   output logic [2:0] state
`ifdef DOOR_NUDGE_EN
   ,
   output logic       nudge
`endif
);

   localparam int TW = timer_width(MOVE_TICKS, DWELL_TICKS);
   localparam logic [TW-1:0] MOVE_TERM  = TW'(MOVE_TICKS - 1);
   localparam logic [TW-1:0] DWELL_TERM = TW'(DWELL_TICKS - 1);

   state_t          state_q;
   state_t          next_state;

   logic            tmr_clear;
   logic            tmr_load;
   logic            tmr_hold;
   logic [TW-1:0]   tmr_load_value;
   logic [TW-1:0]   tmr_terminal;
   logic [TW-1:0]   tmr_count;
   logic            tmr_done;

   logic            other_inhibit;
   logic            open_inhibit;
   logic            close_inhibit;

   // Inhibits other than obstruction always hold the door open.
   assign other_inhibit = open_req | weight_limit_exceeded | sos_mode;

`ifdef DOOR_NUDGE_EN
   localparam int NW = nudge_width(NUDGE_LIMIT);

   logic [NW-1:0]   nudge_cnt;
   logic            nudge_q;
   logic            nudge_due;

   assign nudge_due = (nudge_cnt >= NW'(NUDGE_LIMIT));

   // Once a nudge is due, obstruction is masked in OPEN as well; otherwise a
   // permanently blocked curtain would hold the dwell forever and the nudge
   // close could never start.
   assign open_inhibit  = other_inhibit | (obstruction & ~nudge_due);
   assign close_inhibit = other_inhibit | (obstruction & ~nudge_q);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         nudge_cnt <= '0;
         nudge_q   <= 1'b0;
      end else begin
         if (next_state == CLOSED) begin
            nudge_cnt <= '0;
         end else if ((state_q == CLOSING) && (next_state == OPENING)) begin
            if (other_inhibit)
               nudge_cnt <= '0;
            else if (!nudge_due)
               nudge_cnt <= nudge_cnt + 1'b1;
         end

         // Latched on OPEN->CLOSING, held for that stroke, dropped on exit.
         if (next_state != CLOSING)
            nudge_q <= 1'b0;
         else if (state_q == OPEN)
            nudge_q <= nudge_due;
      end
   end

   assign nudge = nudge_q;
`else
   assign open_inhibit  = other_inhibit | obstruction;
   assign close_inhibit = other_inhibit | obstruction;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n)
         state_q <= CLOSED;
      else
         state_q <= next_state;
   end

   assign tmr_terminal = (state_q == OPEN) ? DWELL_TERM : MOVE_TERM;

   // Next-state and timer control. Within a cycle inhibits beat close_btn,
   // which beats timer expiry.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      next_state     = state_q;
      tmr_clear      = 1'b0;
      tmr_load       = 1'b0;
      tmr_hold       = 1'b0;
      tmr_load_value = '0;

      case (state_q)
         CLOSED: begin
            tmr_hold = 1'b1;
            if (at_floor && (open_req || sos_mode || weight_limit_exceeded)) begin
               next_state = OPENING;
               tmr_clear  = 1'b1;
            end
         end

         OPENING: begin
            if (tmr_done) begin
               next_state = OPEN;
               tmr_clear  = 1'b1;
            end
         end

         OPEN: begin
            if (open_inhibit) begin
               tmr_clear = 1'b1;               // dwell restarts when released
            end else if (close_btn || tmr_done) begin
               next_state = CLOSING;
               tmr_clear  = 1'b1;
            end
         end

         CLOSING: begin
            if (close_inhibit) begin
               // Reopen in the time already spent closing: starting the
               // opening stroke part-way makes it last count+1 cycles.
               next_state     = OPENING;
               tmr_load       = 1'b1;
               tmr_load_value = MOVE_TERM - tmr_count;
            end else if (tmr_done) begin
               next_state = CLOSED;
               tmr_clear  = 1'b1;
            end
         end

         default: begin
            next_state = CLOSED;
            tmr_clear  = 1'b1;
         end
      endcase
   end

   door_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (tmr_clear),
      .load       (tmr_load),
      .load_value (tmr_load_value),
      .hold       (tmr_hold),
      .terminal   (tmr_terminal),
      .count      (tmr_count),
      .done       (tmr_done)
   );

   // Decoded from the state register; OPENING and CLOSING are exclusive, so
   // the motor drives can never both be active.
   assign door        = (state_q != CLOSED);
   assign door_closed = (state_q == CLOSED);
   assign motor_open  = (state_q == OPENING);
   assign motor_close = (state_q == CLOSING);
   assign state       = state_q;

endmodule

// File: tb/tb_door_controller.sv
// -----------------------------------------------------------------------------
// tb_door_controller
// Directed self-checking bench for door_controller with default ticks
// (MOVE_TICKS=4, DWELL_TICKS=10). Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point. Nudge checks are compiled in
// when DOOR_NUDGE_EN is defined.
// -----------------------------------------------------------------------------
module tb_door_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       at_floor;
   logic       open_req;
   logic       close_btn;
   logic       obstruction;
   logic       weight_limit_exceeded;
   logic       sos_mode;
   logic       door;
   logic       door_closed;
   logic       motor_open;
   logic       motor_close;
   logic [2:0] state;
`ifdef DOOR_NUDGE_EN
   logic       nudge;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   door_controller dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .at_floor              (at_floor),
      .open_req              (open_req),
      .close_btn             (close_btn),
      .obstruction           (obstruction),
      .weight_limit_exceeded (weight_limit_exceeded),
      .sos_mode              (sos_mode),
      .door                  (door),
      .door_closed           (door_closed),
      .motor_open            (motor_open),
      .motor_close           (motor_close),
      .state                 (state)
`ifdef DOOR_NUDGE_EN
      ,
      .nudge                 (nudge)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Advance until the FSM shows state s, bounded; the final check reports a
   // timeout as a failed comparison.
   task automatic wait_state(input logic [2:0] s, input string tag);
      int n;
      n = 0;
      while (state !== s && n < 60) begin
         tick();
         n++;
      end
      check(tag, state, s);
   endtask

   // Count consecutive samples spent in state s (bounded).
   task automatic count_in_state(input logic [2:0] s, output int n);
      n = 0;
      while (state === s && n < 200) begin
         tick();
         n++;
      end
   endtask

   // From the current sample, run until door drops, tallying outputs.
   task automatic measure(output int door_n, output int mo_n, output int open_n,
                          output int mc_n, output int both_n);
      door_n = 0; mo_n = 0; open_n = 0; mc_n = 0; both_n = 0;
      while (door === 1'b1 && door_n < 200) begin
         door_n++;
         if (motor_open === 1'b1)  mo_n++;
         if (motor_close === 1'b1) mc_n++;
         if (state === 3'd2)       open_n++;
         if (motor_open === 1'b1 && motor_close === 1'b1) both_n++;
         tick();
      end
   endtask

   task automatic pulse_open();
      open_req = 1'b1;
      tick();
      open_req = 1'b0;
   endtask

   initial begin
      int d, mo, op, mc, bo, n;
      logic stayed;

      reset_n               = 1'b0;
      at_floor              = 1'b1;
      open_req              = 1'b0;
      close_btn             = 1'b0;
      obstruction           = 1'b0;
      weight_limit_exceeded = 1'b0;
      sos_mode              = 1'b0;

      // Reset and idle.
      ticks(2);
      check("rst_state", state, 0);
      check("rst_door", door, 0);
      check("rst_door_closed", door_closed, 1);
      check("rst_motors", {motor_open, motor_close}, 0);
      reset_n = 1'b1;
      ticks(8);
      check("idle_state", state, 0);
      check("idle_motors", {motor_open, motor_close}, 0);

      // Normal cycle: 4 opening + 10 dwell + 4 closing = 18.
      pulse_open();
      check("norm_opening", state, 1);
      measure(d, mo, op, mc, bo);
      check("norm_door_cycles", d, 18);
      check("norm_open_motor", mo, 4);
      check("norm_dwell", op, 10);
      check("norm_close_motor", mc, 4);
      check("norm_motor_overlap", bo, 0);
      check("norm_end_closed", door_closed, 1);

      // Weight hold in OPEN: dwell restarts only once weight drops.
      pulse_open();
      wait_state(3'd2, "wt_reach_open");
      weight_limit_exceeded = 1'b1;
      stayed = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (state !== 3'd2 || door !== 1'b1) stayed = 1'b0;
      end
      check("wt_held_open", stayed, 1);
      weight_limit_exceeded = 1'b0;
      count_in_state(3'd2, n);
      check("wt_dwell_after_drop", n, 10);
      check("wt_then_closing", state, 3);
      measure(d, mo, op, mc, bo);
      check("wt_close_cycles", mc, 4);

      // Reversal after 2 cycles of CLOSING: reopen takes 2 cycles.
      pulse_open();
      wait_state(3'd3, "rev_reach_closing");
      tick();
      check("rev_still_closing", state, 3);
      obstruction = 1'b1;
      tick();
      obstruction = 1'b0;
      check("rev_motor_open", motor_open, 1);
      count_in_state(3'd1, n);
      check("rev_reopen_cycles", n, 2);
      count_in_state(3'd2, n);
      check("rev_full_dwell", n, 10);
      measure(d, mo, op, mc, bo);
      check("rev_close_cycles", mc, 4);
      check("rev_end_state", state, 0);

      // Reversal on the last closing cycle reopens with a full stroke.
      pulse_open();
      wait_state(3'd3, "late_reach_closing");
      ticks(3);
      open_req = 1'b1;
      tick();
      open_req = 1'b0;
      count_in_state(3'd1, n);
      check("late_reopen_cycles", n, 4);
      measure(d, mo, op, mc, bo);

      // close_btn cuts dwell; ignored while obstruction is present.
      pulse_open();
      wait_state(3'd2, "btn_reach_open");
      ticks(2);
      close_btn   = 1'b1;
      obstruction = 1'b1;
      tick();
      check("btn_blocked", state, 2);
      obstruction = 1'b0;
      tick();
      close_btn = 1'b0;
      check("btn_closing", state, 3);
      measure(d, mo, op, mc, bo);
      check("btn_close_cycles", mc, 4);

      // at_floor low: requests do not move a closed door.
      at_floor = 1'b0;
      sos_mode = 1'b1;
      open_req = 1'b1;
      ticks(5);
      check("nofloor_closed", state, 0);
      check("nofloor_door_closed", door_closed, 1);
      open_req = 1'b0;

      // SOS opens from CLOSED and holds OPEN while asserted.
      at_floor = 1'b1;
      tick();
      check("sos_opening", state, 1);
      ticks(20);
      check("sos_open_20", state, 2);
      ticks(20);
      check("sos_open_40", state, 2);
      sos_mode = 1'b0;
      count_in_state(3'd2, n);
      check("sos_dwell_after_drop", n, 10);
      measure(d, mo, op, mc, bo);
      check("sos_end_closed", door_closed, 1);

`ifdef DOOR_NUDGE_EN
      // Three obstruction-only reversals, then a nudge close with the
      // curtain permanently blocked.
      check("nudge_idle", nudge, 0);
      pulse_open();
      for (int r = 0; r < 3; r++) begin
         wait_state(3'd3, "nudge_reach_closing");
         obstruction = 1'b1;
         tick();
         obstruction = 1'b0;
         check("nudge_reversed", state, 1);
      end
      obstruction = 1'b1;
      wait_state(3'd2, "nudge_reach_open");
      wait_state(3'd3, "nudge_reach_close4");
      d = 0;
      n = 0;
      while (state === 3'd3 && n < 50) begin
         if (nudge === 1'b1) d++;
         n++;
         tick();
      end
      check("nudge_close_cycles", n, 4);
      check("nudge_high_cycles", d, 4);
      check("nudge_end_state", state, 0);
      check("nudge_end_flag", nudge, 0);
      obstruction = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
